// File: rtl/voting_pkg.sv
`default_nettype none
// ============================================================================
// Module      : voting_pkg
// Description : Shared sizing constants, default tuning values, storage
//               types and a result-selection helper for the voting machine.
// Revision    : 1.0 - initial release
// ============================================================================
package voting_pkg;

    // Number of candidates, which is also the number of panel buttons.
    localparam int NUM_CANDIDATES = 4;

    // Width of one vote tally. This is also the width of the result bus.
    localparam int TALLY_W = 8;

    // Width of the per-button debounce counter.
    localparam int DEB_CNT_W = 8;

    // Default tuning values. The top-level parameters take these values.
    localparam int                 DEFAULT_DEBOUNCE_CYCLES = 10;
    localparam int                 DEFAULT_ACK_CYCLES      = 10;
    localparam logic [TALLY_W-1:0] DEFAULT_ACK_PATTERN     = 8'hFF;

    typedef logic [TALLY_W-1:0]   tally_t;
    typedef logic [DEB_CNT_W-1:0] deb_cnt_t;

    // Holds every tally. Index k is candidate k, which matches the button
    // numbering [NUM_CANDIDATES:1].
    typedef logic [NUM_CANDIDATES:1][TALLY_W-1:0] tally_bank_t;

    // Returns the tally of the lowest-numbered pressed button, or zero when
    // no button is pressed. The loop runs from the highest index down, so a
    // lower-numbered button overwrites the result and gets priority.
    function automatic tally_t select_tally(
        input logic [NUM_CANDIDATES:1] btn,
        input tally_bank_t             bank
    );
        tally_t sel;
        sel = '0;
        for (int k = NUM_CANDIDATES; k >= 1; k--) begin
            if (btn[k]) begin
                sel = bank[k];
            end
        end
        return sel;
    endfunction

endpackage : voting_pkg
`default_nettype wire

// File: rtl/button_control.sv
`default_nettype none
// ============================================================================
// Module      : button_control
// Description : Debounces one candidate button. It gives a single-cycle
//               vote pulse after DEBOUNCE_CYCLES consecutive high samples
//               taken in voting mode. One continuous press gives one pulse.
//               Another pulse needs at least one low sample first.
// Ports       : clk      - system clock
//               rst      - synchronous active-high reset
//               i_button - raw button level
//               i_mode   - 0 = voting, 1 = result display (holds the count
//                          at zero)
//               o_valid  - registered one-cycle vote pulse
// Revision    : 1.0 - initial release
// ============================================================================
module button_control
    import voting_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_button,
    input  logic i_mode,
    output logic o_valid
);

    localparam deb_cnt_t c_target    = deb_cnt_t'(DEBOUNCE_CYCLES);
    localparam deb_cnt_t c_target_m1 = deb_cnt_t'(DEBOUNCE_CYCLES - 1);
    localparam deb_cnt_t c_one       = deb_cnt_t'(1);

    deb_cnt_t r_count;
    logic     r_valid;
    logic     w_qualified;

    // A sample counts only when the button is high in voting mode.
    // Anything else restarts the run of high samples.
    assign w_qualified = i_button && !i_mode;

    // The counter stops at the target, so a long press cannot roll over
    // and vote a second time. The pulse is registered on the edge that
    // takes the counter from target-1 to target. It is therefore high for
    // exactly the cycle after the DEBOUNCE_CYCLES-th high sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_valid <= 1'b0;
        end else if (!w_qualified) begin
            r_count <= '0;
            r_valid <= 1'b0;
        end else begin
            if (r_count != c_target) begin
                r_count <= r_count + c_one;
            end
            r_valid <= (r_count == c_target_m1);
        end
    end

    assign o_valid = r_valid;

endmodule : button_control
`default_nettype wire

// File: rtl/voting_machine.sv
`default_nettype none
// ============================================================================
// Module      : voting_machine
// Description : Four-candidate voting machine top. It debounces the panel
//               buttons and keeps one saturating 8-bit tally per candidate.
//               It drives a registered result bus:
//                 - voting mode : ACK_PATTERN for ACK_CYCLES cycles after
//                                 each accepted vote, otherwise 0
//                 - result mode : tally of the lowest-numbered pressed
//                                 button, or 0 when no button is pressed
// Ports       : clock       - system clock
//               reset       - synchronous active-high reset
//               mode        - 0 = voting, 1 = result display
//               button[4:1] - candidate buttons, active-high
//               vote_result - registered result / acknowledge bus
// Revision    : 1.0 - initial release
// ============================================================================
module voting_machine
    import voting_pkg::*;
#(
    parameter int     DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int     ACK_CYCLES      = DEFAULT_ACK_CYCLES,
    parameter tally_t ACK_PATTERN     = DEFAULT_ACK_PATTERN
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [NUM_CANDIDATES:1]   button,
    output logic [TALLY_W-1:0]        vote_result
);

    // The acknowledge timer is wide enough to hold ACK_CYCLES and is never
    // narrower than two bits.
    localparam int                 c_ack_w    = $clog2(ACK_CYCLES + 2);
    localparam logic [c_ack_w-1:0] c_ack_load = c_ack_w'(ACK_CYCLES);
    localparam logic [c_ack_w-1:0] c_ack_one  = c_ack_w'(1);
    localparam tally_t             c_tally_one = tally_t'(1);
    localparam tally_t             c_tally_max = '1;

    logic [NUM_CANDIDATES:1] w_valid;
    logic                    w_any_valid;
    tally_bank_t             r_tally;
    logic [c_ack_w-1:0]      r_ack_timer;
    logic [c_ack_w-1:0]      w_ack_timer_next;
    tally_t                  r_vote_result;
    tally_t                  w_vote_result_next;

    // ------------------------------------------------------------------
    // One debouncer per candidate button
    // ------------------------------------------------------------------
    generate
        for (genvar k = 1; k <= NUM_CANDIDATES; k++) begin : g_button
            button_control #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_button_control (
                .clk      (clock),
                .rst      (reset),
                .i_button (button[k]),
                .i_mode   (mode),
                .o_valid  (w_valid[k])
            );
        end
    endgenerate

    assign w_any_valid = |w_valid;

    // ------------------------------------------------------------------
    // Tallies
    // ------------------------------------------------------------------
    // A pulse can still be in flight on the edge where mode goes high,
    // because it was produced from a voting-mode sample. The mode gate
    // keeps the tallies frozen in result mode in that case too. Several
    // candidates can count on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tally <= '0;
        end else if (!mode) begin
            for (int k = 1; k <= NUM_CANDIDATES; k++) begin
                if (w_valid[k] && (r_tally[k] != c_tally_max)) begin
                    r_tally[k] <= r_tally[k] + c_tally_one;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Acknowledge timer and result bus
    // ------------------------------------------------------------------
    // The bus is registered from the timer's next value. The edge that
    // loads the timer therefore also shows the pattern. The pattern lasts
    // exactly ACK_CYCLES cycles, starting one cycle after the vote pulse.
    always_comb begin
        w_ack_timer_next = r_ack_timer;
        if (mode) begin
            w_ack_timer_next = '0;
        end else if (w_any_valid) begin
            w_ack_timer_next = c_ack_load;
        end else if (r_ack_timer != '0) begin
            w_ack_timer_next = r_ack_timer - c_ack_one;
        end
    end

    always_comb begin
        w_vote_result_next = '0;
        if (mode) begin
            w_vote_result_next = select_tally(button, r_tally);
        end else if (w_ack_timer_next != '0) begin
            w_vote_result_next = ACK_PATTERN;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ack_timer   <= '0;
            r_vote_result <= '0;
        end else begin
            r_ack_timer   <= w_ack_timer_next;
            r_vote_result <= w_vote_result_next;
        end
    end

    assign vote_result = r_vote_result;

endmodule : voting_machine
`default_nettype wire

// File: tb/tb_voting_machine.sv
`default_nettype none
// ============================================================================
// Module      : tb_voting_machine
// Description : Self-checking bench for voting_machine. A cycle model
//               pushes the expected bus value for every driven cycle into a
//               scoreboard queue. A negedge monitor pops and compares it.
//               Result-mode readouts are checked against a vector table and
//               hand-written constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_voting_machine;

    localparam int          DEB = 10;
    localparam int          ACK = 10;
    localparam logic [7:0]  PAT = 8'hFF;

    logic       clock;
    logic       reset;
    logic       mode;
    logic [4:1] button;
    logic [7:0] vote_result;

    voting_machine #(
        .DEBOUNCE_CYCLES (DEB),
        .ACK_CYCLES      (ACK),
        .ACK_PATTERN     (PAT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .mode        (mode),
        .button      (button),
        .vote_result (vote_result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int ff_seen = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: behaviour seen at one rising edge
    // ------------------------------------------------------------------
    int         m_run   [1:4];
    bit         m_pulse [1:4];
    int         m_tally [1:4];
    int         m_ack;
    logic [7:0] m_out;

    task automatic model_edge(input logic r, input logic m, input logic [4:1] b);
        bit any;
        if (r) begin
            for (int k = 1; k <= 4; k++) begin
                m_run[k] = 0; m_pulse[k] = 0; m_tally[k] = 0;
            end
            m_ack = 0;
            m_out = 8'h00;
        end else begin
            // A pulse from the previous edge takes effect now.
            any = 0;
            for (int k = 1; k <= 4; k++) begin
                if (m_pulse[k]) any = 1;
                if (m_pulse[k] && !m && m_tally[k] < 255) m_tally[k]++;
            end
            if (m)        m_ack = 0;
            else if (any) m_ack = ACK;
            else if (m_ack > 0) m_ack--;
            if (m) begin
                m_out = 8'h00;
                for (int k = 4; k >= 1; k--) if (b[k]) m_out = 8'(m_tally[k]);
            end else begin
                m_out = (m_ack != 0) ? PAT : 8'h00;
            end
            // The current samples give the next pulses.
            for (int k = 1; k <= 4; k++) begin
                if (b[k] && !m) begin
                    m_pulse[k] = (m_run[k] == DEB - 1);
                    if (m_run[k] < DEB) m_run[k]++;
                end else begin
                    m_run[k] = 0;
                    m_pulse[k] = 0;
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        int         due;
        logic [7:0] exp;
    } sb_t;
    sb_t sb[$];

    always @(negedge clock) begin
        sb_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check("sb_vote_result", int'(vote_result), int'(e.exp));
        end
    end

    task automatic tick(input logic r, input logic m, input logic [4:1] b);
        reset  = r;
        mode   = m;
        button = b;
        model_edge(r, m, b);
        sb.push_back('{due: cyc + 1, exp: m_out});
        @(posedge clock);
        #1;
        if (vote_result == PAT) ff_seen++;
    endtask

    task automatic press(input logic [4:1] b, input int hold, input int rel, input string name);
        ff_seen = 0;
        repeat (hold) tick(1'b0, 1'b0, b);
        check(name, ff_seen, ACK);
        repeat (rel) tick(1'b0, 1'b0, 4'b0000);
    endtask

    task automatic readout(input string name, input logic [4:1] b, input int exp);
        repeat (3) tick(1'b0, 1'b1, b);
        check(name, int'(vote_result), exp);
        tick(1'b0, 1'b1, 4'b0000);
        tick(1'b0, 1'b0, 4'b0000);
    endtask

    typedef struct {
        string      name;
        logic [4:1] btn;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl[9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{"prio_0001", 4'b0001, 8'd4};
        tbl[1] = '{"prio_0010", 4'b0010, 8'd3};
        tbl[2] = '{"prio_0100", 4'b0100, 8'd2};
        tbl[3] = '{"prio_1000", 4'b1000, 8'd1};
        tbl[4] = '{"prio_0110", 4'b0110, 8'd3};
        tbl[5] = '{"prio_0000", 4'b0000, 8'd0};
        tbl[6] = '{"prio_1111", 4'b1111, 8'd4};
        tbl[7] = '{"prio_1100", 4'b1100, 8'd2};
        tbl[8] = '{"prio_1010", 4'b1010, 8'd3};

        // Reset
        repeat (2) tick(1'b1, 1'b0, 4'b0000);
        check("reset_bus", int'(vote_result), 0);
        tick(1'b0, 1'b0, 4'b0000);
        readout("reset_tally1", 4'b0001, 0);
        readout("reset_tally4", 4'b1000, 0);

        // Glitches shorter than the debounce window never vote
        for (int i = 0; i < 3; i++) begin
            repeat (5) tick(1'b0, 1'b0, 4'b0100);
            repeat (5) tick(1'b0, 1'b0, 4'b0000);
            repeat (DEB - 1) tick(1'b0, 1'b0, 4'b0001);
            repeat (3) tick(1'b0, 1'b0, 4'b0000);
        end
        readout("glitch_tally3", 4'b0100, 0);
        readout("glitch_tally1", 4'b0001, 0);

        // Voting sequence: 4/3/2/1 votes
        repeat (4) press(4'b0001, 2000, 200, "ack_len_c1");
        repeat (3) press(4'b0010, 2000, 200, "ack_len_c2");
        repeat (2) press(4'b0100, 2000, 200, "ack_len_c3");
        press(4'b1000, 2000, 200, "ack_len_c4");

        // Result-mode priority table
        for (int i = 0; i < 9; i++) begin
            repeat (3) tick(1'b0, 1'b1, tbl[i].btn);
            check(tbl[i].name, int'(vote_result), int'(tbl[i].exp));
        end
        tick(1'b0, 1'b1, 4'b0000);
        tick(1'b0, 1'b0, 4'b0000);

        // Long presses in result mode change nothing
        repeat (2000) tick(1'b0, 1'b1, 4'b1111);
        tick(1'b0, 1'b1, 4'b0000);
        tick(1'b0, 1'b0, 4'b0000);
        readout("hold_m1_t1", 4'b0001, 4);
        readout("hold_m1_t2", 4'b0010, 3);

        // Mode change mid-press restarts the debounce count
        repeat (6) tick(1'b0, 1'b0, 4'b0001);
        repeat (3) tick(1'b0, 1'b1, 4'b0001);
        ff_seen = 0;
        repeat (DEB - 1) tick(1'b0, 1'b0, 4'b0001);
        check("restart_no_ack", ff_seen, 0);
        repeat (30) tick(1'b0, 1'b0, 4'b0001);
        check("restart_ack", ff_seen, ACK);
        repeat (5) tick(1'b0, 1'b0, 4'b0000);
        readout("restart_t1", 4'b0001, 5);

        // Simultaneous press
        press(4'b0011, 50, 5, "ack_len_both");
        readout("simul_t1", 4'b0001, 6);
        readout("simul_t2", 4'b0010, 4);

        // Reset in the middle of a continuous press
        repeat (5) tick(1'b0, 1'b0, 4'b0011);
        repeat (2) tick(1'b1, 1'b0, 4'b0011);
        check("midreset_bus", int'(vote_result), 0);
        repeat (30) tick(1'b0, 1'b0, 4'b0011);
        repeat (5) tick(1'b0, 1'b0, 4'b0000);
        readout("midreset_t1", 4'b0001, 1);
        readout("midreset_t2", 4'b0010, 1);
        readout("midreset_t3", 4'b0100, 0);

        // Saturation of candidate 2
        for (int i = 0; i < 260; i++) begin
            repeat (DEB + 2) tick(1'b0, 1'b0, 4'b0010);
            tick(1'b0, 1'b0, 4'b0000);
        end
        repeat (15) tick(1'b0, 1'b0, 4'b0000);
        readout("sat_t2", 4'b0010, 255);
        readout("sat_t1", 4'b0001, 1);

        repeat (3) tick(1'b0, 1'b0, 4'b0000);
        @(negedge clock);
        #1;
        check("sb_drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_voting_machine
`default_nettype wire
